// File: rtl/sram_ctrl_if.sv
// Request/response bundle between the memory arbiter (master) and one sram_ctrl (slave).
interface sram_ctrl_if #(
    parameter int ADDR_W = 20,
    parameter int DATA_W = 32
);
    logic                  req_valid;
    logic                  req_ready;
    logic                  req_we;
    logic [DATA_W/8-1:0]   req_be;
    logic [ADDR_W-1:0]     req_addr;
    logic [DATA_W-1:0]     req_wdata;
    logic                  resp_valid;
    logic [DATA_W-1:0]     resp_rdata;

    modport master (
        output req_valid, req_we, req_be, req_addr, req_wdata,
        input  req_ready, resp_valid, resp_rdata
    );

    modport slave (
        input  req_valid, req_we, req_be, req_addr, req_wdata,
        output req_ready, resp_valid, resp_rdata
    );
endinterface

// File: rtl/sram_ctrl.sv
// Async SRAM responder: single-word read/write pin sequencing, optional read buffer (SRAM_CTRL_RDBUF_EN).
// Latency: read RD_WAIT+1, write WR_WAIT+3, buffered read hit 1 cycle from accept to resp_valid.
// Backpressure: req_ready only in IDLE (and not in reset); one request in flight, no back-to-back accept.
module sram_ctrl #(
    parameter int ADDR_W  = 20,
    parameter int DATA_W  = 32,
    parameter int RD_WAIT = 2,
    parameter int WR_WAIT = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    sram_ctrl_if.slave            bus,
    output logic [ADDR_W-1:0]     ram_addr,
    output logic [DATA_W-1:0]     ram_data_o,
    output logic                  ram_data_oe,
    input  logic [DATA_W-1:0]     ram_data_i,
    output logic [DATA_W/8-1:0]   ram_be_n,
    output logic                  ram_ce_n,
    output logic                  ram_oe_n,
    output logic                  ram_we_n
);
    localparam int BE_W     = DATA_W / 8;
    localparam int MAX_WAIT = (RD_WAIT > WR_WAIT) ? RD_WAIT : WR_WAIT;
    localparam int CNT_W    = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;

    typedef enum logic [2:0] {IDLE, RD, WSU, WPL, WHD, RESP} state_t;

    state_t             state, state_nxt;
    logic [CNT_W-1:0]   cnt, cnt_nxt;
    logic [BE_W-1:0]    be_q, be_nxt;
    logic [ADDR_W-1:0]  addr_nxt;
    logic [DATA_W-1:0]  wdata_nxt;
    logic               ce_n_nxt, oe_n_nxt, we_n_nxt, doe_nxt;
    logic [BE_W-1:0]    be_n_nxt;
    logic               accept, hit, rd_done;
    logic               resp_valid_q;
    logic [DATA_W-1:0]  resp_rdata_q;

`ifdef SRAM_CTRL_RDBUF_EN
    logic               buf_vld;
    logic [ADDR_W-1:0]  buf_addr;
    logic [DATA_W-1:0]  buf_dat;
`endif

    assign bus.req_ready  = (state == IDLE) && !reset;
    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_rdata = resp_rdata_q;
    assign accept         = bus.req_valid && bus.req_ready;
    assign rd_done        = (state == RD) && (state_nxt == RESP);

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        be_nxt    = be_q;
        addr_nxt  = ram_addr;
        wdata_nxt = ram_data_o;
        hit       = 1'b0;
`ifdef SRAM_CTRL_RDBUF_EN
        hit = buf_vld && (buf_addr == bus.req_addr);
`endif
        case (state)
            IDLE: begin
                if (accept) begin
                    if (bus.req_we) begin
                        state_nxt = WSU;
                        addr_nxt  = bus.req_addr;
                        be_nxt    = bus.req_be;
                        wdata_nxt = bus.req_wdata;
                    end else if (hit) begin
                        // buffered data returns without touching the pins
                        state_nxt = RESP;
                    end else begin
                        state_nxt = RD;
                        addr_nxt  = bus.req_addr;
                        cnt_nxt   = '0;
                    end
                end
            end
            RD: begin
                if (cnt == CNT_W'(RD_WAIT - 1)) state_nxt = RESP;
                else                            cnt_nxt   = cnt + CNT_W'(1);
            end
            WSU: begin
                state_nxt = WPL;
                cnt_nxt   = '0;
            end
            WPL: begin
                if (cnt == CNT_W'(WR_WAIT - 1)) state_nxt = WHD;
                else                            cnt_nxt   = cnt + CNT_W'(1);
            end
            WHD:     state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase

        // pins are decoded from the next state so they are registered and stable all cycle
        ce_n_nxt = 1'b1;
        oe_n_nxt = 1'b1;
        we_n_nxt = 1'b1;
        be_n_nxt = '1;
        doe_nxt  = 1'b0;
        case (state_nxt)
            RD: begin
                ce_n_nxt = 1'b0;
                oe_n_nxt = 1'b0;
                be_n_nxt = '0;
            end
            WSU, WHD: begin
                ce_n_nxt = 1'b0;
                be_n_nxt = ~be_nxt;
                doe_nxt  = 1'b1;
            end
            WPL: begin
                ce_n_nxt = 1'b0;
                be_n_nxt = ~be_nxt;
                doe_nxt  = 1'b1;
                we_n_nxt = ~(|be_nxt);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            cnt          <= '0;
            be_q         <= '0;
            ram_addr     <= '0;
            ram_data_o   <= '0;
            ram_data_oe  <= 1'b0;
            ram_be_n     <= '1;
            ram_ce_n     <= 1'b1;
            ram_oe_n     <= 1'b1;
            ram_we_n     <= 1'b1;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= '0;
        end else begin
            state        <= state_nxt;
            cnt          <= cnt_nxt;
            be_q         <= be_nxt;
            ram_addr     <= addr_nxt;
            ram_data_o   <= wdata_nxt;
            ram_data_oe  <= doe_nxt;
            ram_be_n     <= be_n_nxt;
            ram_ce_n     <= ce_n_nxt;
            ram_oe_n     <= oe_n_nxt;
            ram_we_n     <= we_n_nxt;
            resp_valid_q <= (state_nxt == RESP);
            if (rd_done)
                resp_rdata_q <= ram_data_i;
`ifdef SRAM_CTRL_RDBUF_EN
            else if (state == IDLE && state_nxt == RESP)
                resp_rdata_q <= buf_dat;
`endif
        end
    end

`ifdef SRAM_CTRL_RDBUF_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            buf_vld  <= 1'b0;
            buf_addr <= '0;
            buf_dat  <= '0;
        end else if (rd_done) begin
            buf_vld  <= 1'b1;
            buf_addr <= ram_addr;
            buf_dat  <= ram_data_i;
        end else if (accept && bus.req_we && (bus.req_addr == buf_addr)) begin
            buf_vld  <= 1'b0;
        end
    end
`endif
endmodule

// File: tb/tb_sram_ctrl.sv
// Bench for sram_ctrl: pin-level SRAM model on the bus, transaction-level reference memory for expected data.
module tb_sram_ctrl;
    localparam int RD_WAIT = 2;
    localparam int WR_WAIT = 2;

    logic        clk;
    logic        reset;
    logic [19:0] ram_addr;
    logic [31:0] ram_data_o;
    logic        ram_data_oe;
    logic [31:0] ram_data_i;
    logic [3:0]  ram_be_n;
    logic        ram_ce_n, ram_oe_n, ram_we_n;

    int tests = 0;
    int fails = 0;
    bit mon_en = 1'b0;
    bit fill   = 1'b0;
    logic [31:0] mem     [256];
    logic [31:0] ref_mem [256];
    logic [31:0] last_rd;
`ifdef SRAM_CTRL_RDBUF_EN
    bit          rb_vld;
    logic [19:0] rb_addr;
`endif

    sram_ctrl_if #(.ADDR_W(20), .DATA_W(32)) bus ();

    sram_ctrl #(.ADDR_W(20), .DATA_W(32), .RD_WAIT(RD_WAIT), .WR_WAIT(WR_WAIT)) dut (
        .clk(clk), .reset(reset), .bus(bus),
        .ram_addr(ram_addr), .ram_data_o(ram_data_o), .ram_data_oe(ram_data_oe),
        .ram_data_i(ram_data_i), .ram_be_n(ram_be_n), .ram_ce_n(ram_ce_n),
        .ram_oe_n(ram_oe_n), .ram_we_n(ram_we_n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] pattern(input int i);
        return 32'hA5C30000 ^ (32'(i) * 32'h01020409);
    endfunction

    // pin-level async SRAM: drives data only while selected and output-enabled
    assign ram_data_i = (!ram_ce_n && !ram_oe_n) ? mem[ram_addr[7:0]] : 32'h0BAD0BAD;

    always @(posedge clk) begin
        if (fill) begin
            for (int i = 0; i < 256; i++) mem[i] <= pattern(i);
        end else if (!ram_ce_n && !ram_we_n && ram_data_oe) begin
            for (int b = 0; b < 4; b++)
                if (!ram_be_n[b]) mem[ram_addr[7:0]][8*b +: 8] <= ram_data_o[8*b +: 8];
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            chk("oe_we_excl", {!ram_oe_n && !ram_we_n, !ram_oe_n && ram_data_oe,
                               !ram_we_n && !ram_data_oe}, 64'd0);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic txn(input logic we, input logic [19:0] addr, input logic [3:0] be,
                       input logic [31:0] wdata);
        int n, lat, we_lo, oe_lo, doe_cyc, ce_lo, pin_bad, exp_lat;
        bit hit;
        hit = 1'b0;
`ifdef SRAM_CTRL_RDBUF_EN
        hit = !we && rb_vld && (rb_addr == addr);
`endif
        bus.req_valid = 1'b1;
        bus.req_we    = we;
        bus.req_addr  = addr;
        bus.req_be    = be;
        bus.req_wdata = wdata;
        n = 0;
        while (bus.req_ready !== 1'b1 && n < 20) begin
            step();
            n++;
        end
        chk("accept_wait", {63'd0, bus.req_ready}, 64'd1);
        step();
        // scramble the request after accept; the controller must have captured it
        bus.req_valid = 1'b0;
        bus.req_we    = 1'($urandom);
        bus.req_addr  = 20'($urandom);
        bus.req_be    = 4'($urandom);
        bus.req_wdata = $urandom;

        lat = 0; we_lo = 0; oe_lo = 0; doe_cyc = 0; ce_lo = 0; pin_bad = 0;
        for (int c = 1; c <= 40; c++) begin
            lat = c;
            if (!ram_ce_n)   ce_lo++;
            if (!ram_we_n)   we_lo++;
            if (!ram_oe_n)   oe_lo++;
            if (ram_data_oe) doe_cyc++;
            if (!ram_ce_n && ram_addr !== addr) pin_bad++;
            if (!ram_ce_n && ram_be_n !== (we ? ~be : 4'h0)) pin_bad++;
            if (ram_data_oe && ram_data_o !== wdata) pin_bad++;
            if (bus.resp_valid === 1'b1) break;
            step();
        end

        exp_lat = we ? WR_WAIT + 3 : (hit ? 1 : RD_WAIT + 1);
        chk("latency",  64'(lat),     64'(exp_lat));
        chk("we_low",   64'(we_lo),   64'((we && be != 4'h0) ? WR_WAIT : 0));
        chk("oe_low",   64'(oe_lo),   64'((!we && !hit) ? RD_WAIT : 0));
        chk("data_oe",  64'(doe_cyc), 64'(we ? WR_WAIT + 2 : 0));
        chk("ce_low",   64'(ce_lo),   64'(we ? WR_WAIT + 2 : (hit ? 0 : RD_WAIT)));
        chk("pin_vals", 64'(pin_bad), 64'd0);

        if (we) begin
            chk("rdata_hold", {32'd0, bus.resp_rdata}, {32'd0, last_rd});
            for (int b = 0; b < 4; b++)
                if (be[b]) ref_mem[addr[7:0]][8*b +: 8] = wdata[8*b +: 8];
`ifdef SRAM_CTRL_RDBUF_EN
            if (rb_addr == addr) rb_vld = 1'b0;
`endif
        end else begin
            chk("rdata", {32'd0, bus.resp_rdata}, {32'd0, ref_mem[addr[7:0]]});
            last_rd = ref_mem[addr[7:0]];
`ifdef SRAM_CTRL_RDBUF_EN
            if (!hit) begin
                rb_vld  = 1'b1;
                rb_addr = addr;
            end
`endif
        end

        chk("ready_in_resp", {63'd0, bus.req_ready}, 64'd0);
        step();
        chk("resp_pulse", {63'd0, bus.resp_valid}, 64'd0);
        chk("ready_after", {63'd0, bus.req_ready}, 64'd1);
    endtask

    initial begin
        int n;
        logic we;
        logic [3:0] be;
        bus.req_valid = 1'b0;
        bus.req_we    = 1'b0;
        bus.req_be    = 4'h0;
        bus.req_addr  = '0;
        bus.req_wdata = '0;
        last_rd       = '0;
`ifdef SRAM_CTRL_RDBUF_EN
        rb_vld  = 1'b0;
        rb_addr = '0;
`endif
        for (int i = 0; i < 256; i++) ref_mem[i] = pattern(i);
        reset = 1'b1;
        fill  = 1'b1;
        step();
        step();
        fill = 1'b0;

        chk("rst_ready",  {63'd0, bus.req_ready},  64'd0);
        chk("rst_pins",   {58'd0, ram_ce_n, ram_oe_n, ram_we_n, ram_data_oe, bus.resp_valid, 1'b0},
                          {58'd0, 6'b111000});
        chk("rst_be_n",   64'(ram_be_n),   64'hF);
        chk("rst_addr",   64'(ram_addr),   64'd0);
        chk("rst_data_o", 64'(ram_data_o), 64'd0);
        chk("rst_rdata",  64'(bus.resp_rdata), 64'd0);
        reset = 1'b0;
        step();
        mon_en = 1'b1;
        chk("ready_after_rst", {63'd0, bus.req_ready}, 64'd1);
        step();
        chk("idle_ce_n", {63'd0, ram_ce_n}, 64'd1);

        txn(1'b1, 20'h00010, 4'hF, 32'hDEADBEEF);
        txn(1'b0, 20'h00010, 4'h0, 32'h0);
        txn(1'b1, 20'h00020, 4'b0101, 32'h11223344);
        txn(1'b0, 20'h00020, 4'h0, 32'h0);
        txn(1'b1, 20'h00021, 4'h0, 32'hCAFEF00D);
        txn(1'b0, 20'h00021, 4'h0, 32'h0);
        // repeated read, then write-invalidate, then read again
        txn(1'b0, 20'h00010, 4'h0, 32'h0);
        txn(1'b0, 20'h00010, 4'h0, 32'h0);
        txn(1'b1, 20'h00010, 4'hF, 32'h0BADCAFE);
        txn(1'b0, 20'h00010, 4'h0, 32'h0);

        for (int k = 0; k < 40; k++) begin
            we = 1'($urandom_range(0, 1));
            be = ($urandom_range(0, 7) == 0) ? 4'h0 : 4'($urandom);
            txn(we, 20'($urandom_range(0, 15)), be, $urandom);
        end

        // reset in the middle of a write pulse
        bus.req_valid = 1'b1;
        bus.req_we    = 1'b1;
        bus.req_addr  = 20'h00030;
        bus.req_be    = 4'hF;
        bus.req_wdata = 32'h55AA55AA;
        n = 0;
        while (bus.req_ready !== 1'b1 && n < 20) begin
            step();
            n++;
        end
        step();
        bus.req_valid = 1'b0;
        step();
        chk("abort_in_wpl", {63'd0, ram_we_n}, 64'd0);
        reset = 1'b1;
        step();
        chk("abort_pins", {60'd0, ram_we_n, ram_ce_n, ram_data_oe, bus.resp_valid}, {60'd0, 4'b1100});
        chk("abort_ready", {63'd0, bus.req_ready}, 64'd0);
        reset = 1'b0;
        for (int c = 0; c < 4; c++) begin
            step();
            chk("abort_no_resp", {63'd0, bus.resp_valid}, 64'd0);
        end
        chk("abort_rdata", 64'(bus.resp_rdata), 64'd0);
        ref_mem[8'h30] = mem[8'h30];
        last_rd = '0;
`ifdef SRAM_CTRL_RDBUF_EN
        rb_vld = 1'b0;
`endif
        txn(1'b0, 20'h00010, 4'h0, 32'h0);
        txn(1'b0, 20'h00010, 4'h0, 32'h0);
        txn(1'b0, 20'h00030, 4'h0, 32'h0);

        mon_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
